pdm_tx: RTL and testbench

PDM_TX -- requirements
Module: pdm_tx

---
 rtl/pdm_tx.sv | 195 +++++++++++++++++++
 tb/tb_pdm_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_tx.sv
// -----------------------------------------------------------------------------
// pdm_tx -- PCM-to-PDM transmitter.
//
// Signed 16-bit PCM samples are queued in a small FIFO and converted to a 1-bit
// pulse-density stream by a first-order sigma-delta accumulator. Each PCM
// sample is held for OSR PDM bits. A bit clock (pdm_clk) is generated by
// dividing g_hclk_es1. The data bit only changes in the cycle where pdm_clk
// falls, so it is stable around every rising edge.
//
// Ports
//   g_hclk_es1   in   sole clock; all state updates on its rising edge
//   hreset       in   asynchronous active-high reset
//   wr_en        in   push wr_data into the sample FIFO
//   wr_data      in   16-bit signed PCM sample
//   enable       in   run the modulator (low returns to IDLE)
//   clr_underrun in   clear the sticky underrun flag
//   pdm_clk      out  generated PDM bit clock
//   pdm_signal   out  PDM data bit
//   full         out  FIFO holds FIFO_DEPTH entries
//   empty        out  FIFO holds no entries
//   level        out  FIFO occupancy
//   underrun     out  sticky: a sample was due while the FIFO was empty
// -----------------------------------------------------------------------------
module pdm_tx #(
  parameter int unsigned CLK_DIV    = 4,   // pdm_clk half-period, 1..255
  parameter int unsigned OSR        = 64,  // PDM bits per PCM sample, 2..256
  parameter int unsigned FIFO_DEPTH = 8    // power of two
) (
  input  logic                          g_hclk_es1,
  input  logic                          hreset,
  input  logic                          wr_en,
  input  logic [15:0]                   wr_data,
  input  logic                          enable,
  input  logic                          clr_underrun,
  output logic                          pdm_clk,
  output logic                          pdm_signal,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(OSR);

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [7:0]      div_q, div_d;
  logic            pclk_q, pclk_d;
  logic            pdm_q, pdm_d;
  logic [15:0]     acc_q, acc_d;
  logic [15:0]     cur_q, cur_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            underrun_q, underrun_d;

  logic [15:0]     mem [FIFO_DEPTH];

  logic            step;
  logic            pop;
  logic            push;
  logic            fifo_empty;
  logic            fifo_full;
  logic [15:0]     sample;
  logic [16:0]     sum;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    pclk_d     = pclk_q;
    pdm_d      = pdm_q;
    acc_d      = acc_q;
    cur_d      = cur_q;
    bit_d      = bit_q;
    step       = 1'b0;
    pop        = 1'b0;
    sample     = cur_q;
    sum        = '0;
    underrun_d = underrun_q & ~clr_underrun;

    unique case (state_q)
      IDLE: begin
        div_d  = '0;
        pclk_d = 1'b0;
        pdm_d  = 1'b0;
        acc_d  = '0;
        bit_d  = '0;
        if (enable) begin
          state_d = RUN;
          step    = 1'b1;  // first bit is produced on the entry cycle
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          div_d   = '0;
          pclk_d  = 1'b0;
          pdm_d   = 1'b0;
          acc_d   = '0;
          bit_d   = '0;
        end else if (div_q == 8'(CLK_DIV - 1)) begin
          div_d  = '0;
          pclk_d = ~pclk_q;
          step   = pclk_q;  // step only when pdm_clk falls
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (step) begin
      if (bit_q == '0) begin
        if (fifo_empty) begin
          sample     = 16'h0000;
          underrun_d = 1'b1;  // set wins over a same-cycle clear
        end else begin
          sample = mem[rd_ptr_q];
          pop    = 1'b1;
        end
        cur_d = sample;
      end
      // Inverting the MSB maps signed PCM onto an unsigned offset-binary
      // value, so the carry out of the accumulator is the PDM bit.
      sum   = {1'b0, acc_q} + {1'b0, sample ^ 16'h8000};
      pdm_d = sum[16];
      acc_d = sum[15:0];
      bit_d = (bit_q == BW'(OSR - 1)) ? '0 : bit_q + BW'(1);
    end
  end

  // A write is also accepted when full if the same cycle pops; a pop from an
  // empty FIFO never happens, so an empty-cycle write is simply stored.
  always_comb begin
    push     = wr_en & (~fifo_full | pop);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge g_hclk_es1 or posedge hreset) begin
    if (hreset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      pclk_q     <= 1'b0;
      pdm_q      <= 1'b0;
      acc_q      <= '0;
      cur_q      <= '0;
      bit_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      pclk_q     <= pclk_d;
      pdm_q      <= pdm_d;
      acc_q      <= acc_d;
      cur_q      <= cur_d;
      bit_q      <= bit_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
    end
  end

  // NOTE: the storage array is not reset; flushing the pointers and level is
  // enough, and stale contents are never read.
  always_ff @(posedge g_hclk_es1) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign pdm_clk    = pclk_q;
  assign pdm_signal = pdm_q;
  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign level      = level_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_pdm_tx.sv
// -----------------------------------------------------------------------------
// tb_pdm_tx -- self-checking bench for pdm_tx.
// Expected PDM bits come from an arithmetic model: with an unbounded running
// total T of offset-binary sample values, bit k of the stream is
// floor((T+u)/2^16) - floor(T/2^16).
// -----------------------------------------------------------------------------
module tb_pdm_tx;

  localparam int CLK_DIV = 4;
  localparam int OSR     = 64;
  localparam int DEPTH   = 8;

  logic        clk = 1'b0;
  logic        hreset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        enable;
  logic        clr_underrun;

  logic        pdm_clk, pdm_signal, full, empty, underrun;
  logic [3:0]  level;
  logic        p1_clk, p1_sig, p1_full, p1_empty, p1_underrun;
  logic [3:0]  p1_level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_fifo[$];
  bit          exp_q[$];
  bit          got_q[$];
  int          rise_cyc[$];
  longint      model_t;

  always #5 clk = ~clk;

  pdm_tx #(.CLK_DIV(CLK_DIV), .OSR(OSR), .FIFO_DEPTH(DEPTH)) dut (
    .g_hclk_es1(clk), .hreset(hreset), .wr_en(wr_en), .wr_data(wr_data),
    .enable(enable), .clr_underrun(clr_underrun), .pdm_clk(pdm_clk),
    .pdm_signal(pdm_signal), .full(full), .empty(empty), .level(level),
    .underrun(underrun)
  );

  pdm_tx #(.CLK_DIV(1), .OSR(OSR), .FIFO_DEPTH(DEPTH)) dut1 (
    .g_hclk_es1(clk), .hreset(hreset), .wr_en(wr_en), .wr_data(wr_data),
    .enable(enable), .clr_underrun(clr_underrun), .pdm_clk(p1_clk),
    .pdm_signal(p1_sig), .full(p1_full), .empty(p1_empty), .level(p1_level),
    .underrun(p1_underrun)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_sample(input logic [15:0] s);
    longint u = longint'(s ^ 16'h8000);
    for (int k = 0; k < OSR; k++) begin
      exp_q.push_back(bit'(((model_t + u) >> 16) - (model_t >> 16)));
      model_t += u;
    end
  endfunction

  function automatic void model_due();
    logic [15:0] s = 16'h0000;
    if (model_fifo.size() > 0) s = model_fifo.pop_front();
    model_sample(s);
  endfunction

  task automatic push(input logic [15:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    @(negedge clk);
    wr_en   = 1'b0;
    if (model_fifo.size() < DEPTH) model_fifo.push_back(v);
  endtask

  // Record pdm_signal at each pdm_clk rise until got_q holds n bits.
  task automatic collect(input int n, input int budget);
    int   cyc  = 0;
    logic prev = pdm_clk;
    rise_cyc.delete();
    while (got_q.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (pdm_clk && !prev) begin
        got_q.push_back(pdm_signal);
        rise_cyc.push_back(cyc);
      end
      prev = pdm_clk;
    end
    check("collect_count", got_q.size(), n);
  endtask

  task automatic compare_bits(input string tag, input int first, input int n);
    int mism = 0;
    for (int i = first; i < first + n; i++)
      if (i >= got_q.size() || i >= exp_q.size() || got_q[i] != exp_q[i]) mism++;
    check(tag, mism, 0);
  endtask

  function automatic int ones(input int first, input int n);
    int c = 0;
    for (int i = first; i < first + n && i < got_q.size(); i++) c += int'(got_q[i]);
    return c;
  endfunction

  task automatic start_run();
    got_q.delete();
    exp_q.delete();
    model_t = 0;
    enable  = 1'b1;
  endtask

  initial begin
    logic [15:0] vals[9];
    logic        prev_clk, prev_sig;
    int          waited;

    hreset = 1'b1; wr_en = 1'b0; wr_data = '0; enable = 1'b0; clr_underrun = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pdm_clk", pdm_clk, 0);
    check("rst_pdm_signal", pdm_signal, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_underrun", underrun, 0);
    hreset = 1'b0;
    @(negedge clk);

    // Mid-scale: 0x0000 gives alternating bits, 50% density.
    push(16'h0000);
    check("mid_level", level, 1);
    check("mid_empty", empty, 0);
    start_run();
    model_due();
    collect(OSR, 40 * OSR);
    // Entry edge is cycle 0; first rise lands CLK_DIV edges later, seen at the
    // following negedge.
    check("mid_first_rise", (rise_cyc.size() > 0) ? rise_cyc[0] : -1, CLK_DIV + 1);
    check("mid_period", (rise_cyc.size() > 1) ? rise_cyc[1] - rise_cyc[0] : -1, 2 * CLK_DIV);
    compare_bits("mid_bits", 0, OSR);
    check("mid_bit0", got_q[0], 0);
    check("mid_bit1", got_q[1], 1);
    check("mid_density", ones(0, OSR), 32);
    check("mid_underrun", underrun, 0);
    check("mid_empty_after", empty, 1);
    enable = 1'b0;
    @(negedge clk);
    check("idle_pdm_clk", pdm_clk, 0);
    check("idle_pdm_signal", pdm_signal, 0);

    // Extremes: full positive then full negative.
    push(16'h7FFF);
    push(16'h8000);
    start_run();
    model_due();
    model_due();
    collect(2 * OSR, 40 * OSR);
    compare_bits("ext_bits_pos", 0, OSR);
    compare_bits("ext_bits_neg", OSR, OSR);
    check("ext_pos_ones", ones(0, OSR), 63);
    check("ext_pos_bit0", got_q[0], 0);
    check("ext_neg_ones", ones(OSR, OSR), 0);
    enable = 1'b0;
    @(negedge clk);

    // FIFO full: nine writes, ninth dropped.
    for (int i = 0; i < 9; i++) begin
      vals[i] = {16'($urandom) & 16'hFFF0} | 16'(i);
      push(vals[i]);
      check($sformatf("full_level_%0d", i), level, (i + 1 > DEPTH) ? DEPTH : i + 1);
      check($sformatf("full_flag_%0d", i), full, (i >= DEPTH - 1) ? 1 : 0);
    end
    start_run();
    for (int i = 0; i < DEPTH; i++) model_due();
    collect(DEPTH * OSR, 40 * DEPTH * OSR);
    for (int i = 0; i < DEPTH; i++) compare_bits($sformatf("play_sample_%0d", i), i * OSR, OSR);
    check("play_underrun", underrun, 0);
    check("play_empty", empty, 1);
    enable = 1'b0;
    @(negedge clk);

    // Underrun: run with the FIFO empty.
    start_run();
    model_due();
    @(negedge clk);
    check("ur_set_entry", underrun, 1);
    collect(4, 40 * 4);
    compare_bits("ur_bits", 0, 4);
    check("ur_bit1", got_q[1], 1);
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    check("ur_cleared", underrun, 0);
    collect(OSR, 40 * OSR);
    waited = 0;
    while (!underrun && waited < 4 * CLK_DIV + 4) begin
      @(negedge clk);
      waited++;
    end
    check("ur_reset_due", underrun, 1);

    // Reset asserted mid-run while pdm_clk is high and FIFO holds data.
    push(16'h1234);
    push(16'hABCD);
    check("rr_level_pre", level, 2);
    waited = 0;
    while (!pdm_clk && waited < 4 * CLK_DIV) begin
      @(negedge clk);
      waited++;
    end
    check("rr_clk_high", pdm_clk, 1);
    #2 hreset = 1'b1;
    #1;
    check("rr_pdm_clk", pdm_clk, 0);
    check("rr_pdm_signal", pdm_signal, 0);
    check("rr_empty", empty, 1);
    check("rr_full", full, 0);
    check("rr_level", level, 0);
    check("rr_underrun", underrun, 0);
    enable = 1'b0;
    model_fifo.delete();
    @(negedge clk);
    hreset = 1'b0;
    @(negedge clk);

    // CLK_DIV=1: pdm_clk toggles every cycle, data changes only on falls.
    push(16'($urandom));
    start_run();
    model_due();
    prev_clk = p1_clk;
    prev_sig = p1_sig;
    for (int k = 1; k <= 2 * OSR; k++) begin
      @(negedge clk);
      check($sformatf("d1_clk_%0d", k), p1_clk, (k % 2 == 0) ? 1 : 0);
      if (k >= 2)
        check($sformatf("d1_sig_edge_%0d", k), (p1_sig == prev_sig) || (prev_clk && !p1_clk), 1);
      if (p1_clk && !prev_clk) got_q.push_back(p1_sig);
      prev_clk = p1_clk;
      prev_sig = p1_sig;
    end
    compare_bits("d1_bits", 0, OSR);
    enable = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
